// File: rtl/tetris_drop_sched.sv
// Gravity scheduler: maps the BCD level to a drop period and raises drop_req_o each time it expires.
// drop_req_o rises one cycle after the expiring ms tick and is held (counters frozen) until drop_ack_i.
module tetris_drop_sched #(
    parameter int CLK_HZ         = 25_000_000,
    parameter int BASE_PERIOD_MS = 1000,
    parameter int STEP_MS        = 50,
    parameter int MIN_PERIOD_MS  = 100,
    parameter int SOFT_MS        = 30
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            new_game_i,
    input  logic            start_i,
    input  logic [1:0][3:0] level_i,
    input  logic            level_changed_i,
    input  logic            pause_i,
    input  logic            soft_drop_i,
    input  logic            drop_ack_i,
    output logic            drop_req_o,
    output logic [15:0]     period_ms_o,
    output logic            running_o
);

    localparam int CLKS_PER_MS = CLK_HZ / 1000;
    localparam int PW          = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_MS - 1);
    localparam logic [31:0]   BASE32  = 32'(BASE_PERIOD_MS);
    localparam logic [31:0]   MIN32   = 32'(MIN_PERIOD_MS);
    localparam logic [15:0]   SOFT16  = 16'(SOFT_MS);
    localparam logic [15:0]   BASE16  = 16'(BASE_PERIOD_MS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_REQ} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;
    logic [15:0]   period_q, period_d;

    logic [3:0]  tens, units;
    logic [6:0]  lvl;
    logic [31:0] dec;
    logic [15:0] period_ld;
    logic [15:0] tgt;

    // Level decode and period computed at 32 bits so the subtraction saturates instead of wrapping.
    always_comb begin
        tens  = (level_i[1] > 4'd9) ? 4'd9 : level_i[1];
        units = (level_i[0] > 4'd9) ? 4'd9 : level_i[0];
        lvl   = {3'b000, tens} * 7'd10 + {3'b000, units};
        if (lvl == 7'd0) begin
            lvl = 7'd1;
        end
        dec = 32'(STEP_MS) * 32'(lvl - 7'd1);
        if ((dec >= BASE32) || ((BASE32 - dec) < MIN32)) begin
            period_ld = 16'(MIN32);
        end else begin
            period_ld = 16'(BASE32 - dec);
        end
    end

    assign tgt = (soft_drop_i && (period_q > SOFT16)) ? SOFT16 : period_q;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        ms_d     = ms_q;
        period_d = period_q;
        if (new_game_i) begin
            state_d  = S_IDLE;
            presc_d  = '0;
            ms_d     = '0;
            period_d = BASE16;
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    ms_d    = '0;
                    if (start_i) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    period_d = period_ld;
                    presc_d  = '0;
                    state_d  = S_COUNT;
                end
                S_COUNT: begin
                    if (!pause_i) begin
                        if (presc_q == PRE_MAX) begin
                            presc_d = '0;
                            ms_d    = ms_q + 16'd1;
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                    // Expiry outranks a level change; the following LOAD resamples the level anyway.
                    if (ms_q >= tgt) begin
                        state_d = S_REQ;
                        presc_d = '0;
                        ms_d    = '0;
                    end else if (level_changed_i) begin
                        state_d = S_LOAD;
                    end
                end
                S_REQ: begin
                    if (drop_ack_i) begin
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            ms_q     <= '0;
            period_q <= BASE16;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            period_q <= period_d;
        end
    end

    assign drop_req_o  = (state_q == S_REQ);
    assign running_o   = (state_q != S_IDLE);
    assign period_ms_o = period_q;

endmodule
